// File: rtl/nibble_serial_comparator.sv
// rtl/nibble_serial_comparator.sv - multi-cycle nibble-serial EQ/LT/LTU comparator
//
// Compares two WIDTH-bit operands DIGIT bits per cycle, least significant
// nibble first. The flags are resolved on the final (most significant) nibble.
//
// Ports:
//   CLK    - clock; all state changes on the rising edge
//   RST    - synchronous active-high reset (wins over START)
//   START  - compare request, accepted in IDLE or DONE
//   A, B   - operands, captured when START is accepted
//   BUSY   - high while nibbles are being processed (RUN)
//   VALID  - one-cycle pulse while in DONE; the flags are final
//   EQ     - A == B
//   LT     - A < B, two's-complement signed
//   LTU    - A < B, unsigned
module nibble_serial_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             VALID,
  output logic             EQ,
  output logic             LT,
  output logic             LTU
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Flipping the nibble MSB maps two's-complement order onto unsigned order,
  // so the signed compare reuses the same unsigned magnitude comparator.
  localparam logic [DIGIT-1:0] SIGN_MASK = DIGIT'(1) << (DIGIT - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             eq_acc;
  logic             lt_acc;

  logic [DIGIT-1:0] a_n;
  logic [DIGIT-1:0] b_n;
  logic             nib_eq;
  logic             nib_lt;
  logic             nib_lts;
  logic             last;

  assign a_n     = a_sh[DIGIT-1:0];
  assign b_n     = b_sh[DIGIT-1:0];
  assign nib_eq  = (a_n == b_n);
  assign nib_lt  = (a_n < b_n);
  assign nib_lts = ((a_n ^ SIGN_MASK) < (b_n ^ SIGN_MASK));
  assign last    = (cnt == CW'(NDIG - 1));

  assign BUSY  = (state == S_RUN);
  assign VALID = (state == S_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      eq_acc <= 1'b0;
      lt_acc <= 1'b0;
      EQ     <= 1'b0;
      LT     <= 1'b0;
      LTU    <= 1'b0;
    end else begin
      case (state)
        // DONE accepts START as well, giving back-to-back compares.
        S_IDLE, S_DONE: begin
          if (START) begin
            state  <= S_RUN;
            a_sh   <= A;
            b_sh   <= B;
            cnt    <= '0;
            eq_acc <= 1'b1;
            lt_acc <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          eq_acc <= eq_acc & nib_eq;
          // A differing nibble overrides whatever the lower nibbles decided.
          if (!nib_eq) begin
            lt_acc <= nib_lt;
          end
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          cnt  <= cnt + 1'b1;
          if (last) begin
            // Flags are written only here, so they never show partial results.
            state <= S_DONE;
            EQ    <= eq_acc & nib_eq;
            LTU   <= nib_eq ? lt_acc : nib_lt;
            LT    <= nib_eq ? lt_acc : nib_lts;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// tb/tb_nibble_serial_comparator.sv - randomized self-checking bench for nibble_serial_comparator
module tb_nibble_serial_comparator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        VALID;
  logic        EQ;
  logic        LT;
  logic        LTU;

  int checks   = 0;
  int failures = 0;

  nibble_serial_comparator #(.WIDTH(32), .DIGIT(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .VALID (VALID),
    .EQ    (EQ),
    .LT    (LT),
    .LTU   (LTU)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs from the sample just after the accepting edge until VALID is seen,
  // scrambling A/B/START meanwhile to show RUN ignores them.
  task automatic wait_valid(output int cyc, output int busyc);
    cyc   = 0;
    busyc = 0;
    while (!VALID && cyc < 20) begin
      if (BUSY) busyc++;
      START = 1'($urandom_range(0, 1));
      A     = $urandom;
      B     = $urandom;
      tick();
      cyc++;
    end
    START = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input int cyc, input int busyc);
    check({tag, "_latency"}, cyc + 1, 9);
    check({tag, "_busy_cycles"}, busyc, 8);
    check({tag, "_busy_at_valid"}, {31'd0, BUSY}, 0);
    check({tag, "_eq"}, {31'd0, EQ}, {31'd0, a == b});
    check({tag, "_lt"}, {31'd0, LT}, {31'd0, $signed(a) < $signed(b)});
    check({tag, "_ltu"}, {31'd0, LTU}, {31'd0, a < b});
  endtask

  task automatic do_compare(input string tag, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    int busyc;
    logic [2:0] flags;
    A     = a;
    B     = b;
    START = 1'b1;
    tick();
    wait_valid(cyc, busyc);
    check_result(tag, a, b, cyc, busyc);
    flags = {EQ, LT, LTU};
    tick();
    check({tag, "_valid_pulse"}, {31'd0, VALID}, 0);
    check({tag, "_hold"}, {29'd0, EQ, LT, LTU}, {29'd0, flags});
  endtask

  initial begin
    int cyc;
    int busyc;
    int seen_valid;
    logic [31:0] ra;
    logic [31:0] rb;

    RST   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    check("rst_busy",  {31'd0, BUSY},  0);
    check("rst_valid", {31'd0, VALID}, 0);
    check("rst_flags", {29'd0, EQ, LT, LTU}, 0);
    RST = 1'b0;
    tick();

    do_compare("eq5",     32'h0000_0005, 32'h0000_0005);
    do_compare("neg1_1",  32'hFFFF_FFFF, 32'h0000_0001);
    do_compare("min_max", 32'h8000_0000, 32'h7FFF_FFFF);
    do_compare("ovr",     32'h0000_0010, 32'h0000_0001);
    do_compare("ovr_sw",  32'h0000_0001, 32'h0000_0010);

    // Back-to-back with START held high.
    A     = 32'd1;
    B     = 32'd2;
    START = 1'b1;
    tick();
    wait_valid(cyc, busyc);
    check_result("b2b_first", 32'd1, 32'd2, cyc, busyc);
    A     = 32'd3;
    B     = 32'd3;
    START = 1'b1;
    tick();
    wait_valid(cyc, busyc);
    check_result("b2b_second", 32'd3, 32'd3, cyc, busyc);
    tick();

    // Reset in the 4th RUN cycle aborts the compare.
    do_compare("pre_rst", 32'h1234_5678, 32'h1234_5678);
    A     = 32'h0000_0001;
    B     = 32'h0000_0001;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_busy",  {31'd0, BUSY},  0);
    check("abort_valid", {31'd0, VALID}, 0);
    check("abort_flags", {29'd0, EQ, LT, LTU}, 0);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      if (VALID) seen_valid++;
      tick();
    end
    check("abort_no_valid", seen_valid, 0);
    do_compare("post_rst", 32'hFFFF_FFF0, 32'h0000_0000);

    // RST and START together: reset wins.
    RST   = 1'b1;
    START = 1'b1;
    A     = 32'd7;
    B     = 32'd9;
    tick();
    check("rst_start_busy", {31'd0, BUSY}, 0);
    RST   = 1'b0;
    START = 1'b0;
    tick();
    check("rst_start_idle", {30'd0, BUSY, VALID}, 0);

    // Random operands, biased so many nibbles are shared.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = ra;
        2:       rb = ra ^ (32'hF << (4 * $urandom_range(0, 7)));
        default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        do_compare($sformatf("rnd%0d", i), ra, rb);
      end else begin
        do_compare($sformatf("rnd%0d", i), rb, ra);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
